// File: rtl/axi_pkg.sv
// Shared AXI read definitions for the read arbiter slice.
// Holds the arbiter FSM state encoding, the AXI sideband field widths
// and the INCR burst code.
package axi_pkg;

  localparam int unsigned ID_W    = 2;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant decision.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i[1:0]    : requester valids {M1, M0}
//   done_i        : current burst finished (LAST handshake)
//   owner_i       : index of the requester that owned the finished burst
//   gnt_o         : index to grant when arbitration happens this cycle
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       owner_i,
  output logic       gnt_o
);

  logic rr_q, rr_d;

  // Pointer favours the requester that did not own the last burst.
  always_comb begin
    rr_d = rr_q;
    if (done_i) rr_d = ~owner_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

  always_comb begin
    gnt_o = 1'b0;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = rr_q;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI read arbiter, one burst outstanding.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   M{0,1}_RD_ADDR_*    : requester read-address channel (VALID in, READY out)
//   M{0,1}_RD_BACK_*    : read data returned to requester, with DATA_VALID out
//                         and DATA_READY in
//   S_RD_ADDR_*         : shared slave address channel (READY in)
//   S_RD_BACK_*         : shared slave data channel (DATA_READY out)
//   GRANT               : current owner index, meaningful outside IDLE
//   BURST_ERR           : sticky beat-count / LAST mismatch flag
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ID_W-1:0]       M0_RD_ADDR_ID,
  input  logic [ADDR_WIDTH-1:0] M0_RD_ADDR_ADDR,
  input  logic [LEN_W-1:0]      M0_RD_ADDR_LEN,
  input  logic [BURST_W-1:0]    M0_RD_ADDR_BURST,
  input  logic                  M0_RD_ADDR_VALID,
  output logic                  M0_RD_ADDR_READY,
  output logic [ID_W-1:0]       M0_RD_BACK_ID,
  output logic [DATA_WIDTH-1:0] M0_RD_BACK_DATA,
  output logic [RESP_W-1:0]     M0_RD_BACK_RESP,
  output logic                  M0_RD_BACK_LAST,
  output logic                  M0_RD_DATA_VALID,
  input  logic                  M0_RD_DATA_READY,
  input  logic [ID_W-1:0]       M1_RD_ADDR_ID,
  input  logic [ADDR_WIDTH-1:0] M1_RD_ADDR_ADDR,
  input  logic [LEN_W-1:0]      M1_RD_ADDR_LEN,
  input  logic [BURST_W-1:0]    M1_RD_ADDR_BURST,
  input  logic                  M1_RD_ADDR_VALID,
  output logic                  M1_RD_ADDR_READY,
  output logic [ID_W-1:0]       M1_RD_BACK_ID,
  output logic [DATA_WIDTH-1:0] M1_RD_BACK_DATA,
  output logic [RESP_W-1:0]     M1_RD_BACK_RESP,
  output logic                  M1_RD_BACK_LAST,
  output logic                  M1_RD_DATA_VALID,
  input  logic                  M1_RD_DATA_READY,
  output logic [ID_W-1:0]       S_RD_ADDR_ID,
  output logic [ADDR_WIDTH-1:0] S_RD_ADDR_ADDR,
  output logic [LEN_W-1:0]      S_RD_ADDR_LEN,
  output logic [BURST_W-1:0]    S_RD_ADDR_BURST,
  output logic                  S_RD_ADDR_VALID,
  input  logic                  S_RD_ADDR_READY,
  input  logic [ID_W-1:0]       S_RD_BACK_ID,
  input  logic [DATA_WIDTH-1:0] S_RD_BACK_DATA,
  input  logic [RESP_W-1:0]     S_RD_BACK_RESP,
  input  logic                  S_RD_BACK_LAST,
  input  logic                  S_RD_BACK_VALID,
  output logic                  S_RD_DATA_READY,
  output logic                  GRANT,
  output logic                  BURST_ERR
);

  rd_state_t        state_q, state_d;
  logic             grant_q, grant_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] exp_len_q, exp_len_d;
  logic             err_q, err_d;

  logic                  arb_gnt;
  logic                  addr_hs, data_hs, last_hs;
  logic                  sel_valid, sel_dready;
  logic [ID_W-1:0]       sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_W-1:0]      sel_len;
  logic [BURST_W-1:0]    sel_burst;

  rr_arbiter2 u_rr (
    .clk_i   (CLK),
    .rst_i   (RST),
    .req_i   ({M1_RD_ADDR_VALID, M0_RD_ADDR_VALID}),
    .done_i  (last_hs),
    .owner_i (grant_q),
    .gnt_o   (arb_gnt)
  );

  // Granted requester's address payload and data-ready.
  always_comb begin
    if (grant_q) begin
      sel_valid  = M1_RD_ADDR_VALID;
      sel_id     = M1_RD_ADDR_ID;
      sel_addr   = M1_RD_ADDR_ADDR;
      sel_len    = M1_RD_ADDR_LEN;
      sel_burst  = M1_RD_ADDR_BURST;
      sel_dready = M1_RD_DATA_READY;
    end else begin
      sel_valid  = M0_RD_ADDR_VALID;
      sel_id     = M0_RD_ADDR_ID;
      sel_addr   = M0_RD_ADDR_ADDR;
      sel_len    = M0_RD_ADDR_LEN;
      sel_burst  = M0_RD_ADDR_BURST;
      sel_dready = M0_RD_DATA_READY;
    end
  end

  assign addr_hs = (state_q == ST_ADDR) && sel_valid && S_RD_ADDR_READY;
  assign data_hs = (state_q == ST_DATA) && S_RD_BACK_VALID && sel_dready;
  assign last_hs = data_hs && S_RD_BACK_LAST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      cnt_q     <= '0;
      exp_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      exp_len_q <= exp_len_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    exp_len_d = exp_len_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (M0_RD_ADDR_VALID || M1_RD_ADDR_VALID) begin
          grant_d = arb_gnt;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (addr_hs) begin
          state_d   = ST_DATA;
          exp_len_d = sel_len;
          cnt_d     = '0;
        end
      end
      ST_DATA: begin
        if (data_hs) begin
          if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
          // cnt_q is the zero-based index of this beat; LAST belongs on index exp_len.
          if ((S_RD_BACK_LAST && (cnt_q != exp_len_q)) ||
              (!S_RD_BACK_LAST && (cnt_q == exp_len_q)))
            err_d = 1'b1;
          if (S_RD_BACK_LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while RST is high, independent of the current state.
  always_comb begin
    M0_RD_ADDR_READY = 1'b0;
    M1_RD_ADDR_READY = 1'b0;
    M0_RD_BACK_ID    = '0;
    M0_RD_BACK_DATA  = '0;
    M0_RD_BACK_RESP  = '0;
    M0_RD_BACK_LAST  = 1'b0;
    M0_RD_DATA_VALID = 1'b0;
    M1_RD_BACK_ID    = '0;
    M1_RD_BACK_DATA  = '0;
    M1_RD_BACK_RESP  = '0;
    M1_RD_BACK_LAST  = 1'b0;
    M1_RD_DATA_VALID = 1'b0;
    S_RD_ADDR_ID     = '0;
    S_RD_ADDR_ADDR   = '0;
    S_RD_ADDR_LEN    = '0;
    S_RD_ADDR_BURST  = '0;
    S_RD_ADDR_VALID  = 1'b0;
    S_RD_DATA_READY  = 1'b0;
    GRANT            = 1'b0;
    BURST_ERR        = 1'b0;
    if (!RST) begin
      GRANT     = grant_q;
      BURST_ERR = err_q;
      case (state_q)
        ST_ADDR: begin
          S_RD_ADDR_ID    = sel_id;
          S_RD_ADDR_ADDR  = sel_addr;
          S_RD_ADDR_LEN   = sel_len;
          S_RD_ADDR_BURST = sel_burst;
          S_RD_ADDR_VALID = sel_valid;
          if (grant_q) M1_RD_ADDR_READY = S_RD_ADDR_READY;
          else         M0_RD_ADDR_READY = S_RD_ADDR_READY;
        end
        ST_DATA: begin
          S_RD_DATA_READY = sel_dready;
          if (grant_q) begin
            M1_RD_BACK_ID    = S_RD_BACK_ID;
            M1_RD_BACK_DATA  = S_RD_BACK_DATA;
            M1_RD_BACK_RESP  = S_RD_BACK_RESP;
            M1_RD_BACK_LAST  = S_RD_BACK_LAST;
            M1_RD_DATA_VALID = S_RD_BACK_VALID;
          end else begin
            M0_RD_BACK_ID    = S_RD_BACK_ID;
            M0_RD_BACK_DATA  = S_RD_BACK_DATA;
            M0_RD_BACK_RESP  = S_RD_BACK_RESP;
            M0_RD_BACK_LAST  = S_RD_BACK_LAST;
            M0_RD_DATA_VALID = S_RD_BACK_VALID;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the read-address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, is the read-data width on all ports.
REQ-003 CLK  in  1  is the single clock; all logic is on its rising edge.
REQ-004 RST  in  1  is the reset: synchronous, active-high.
REQ-005 M{0,1}_RD_ADDR_ID/ADDR/LEN/BURST  in  2/ADDR_WIDTH/8/2  is the requester read-address payload.
REQ-006 M{0,1}_RD_ADDR_VALID  in  1  and  M{0,1}_RD_ADDR_READY  out  1  are the requester read-address handshake.
REQ-007 M{0,1}_RD_BACK_ID/DATA/RESP/LAST  out  2/DATA_WIDTH/2/1  is the read-data payload returned to the requester.
REQ-008 M{0,1}_RD_DATA_VALID  out  1  and  M{0,1}_RD_DATA_READY  in  1  are the requester read-data handshake.
REQ-009 S_RD_ADDR_ID/ADDR/LEN/BURST/VALID  out  2/ADDR_WIDTH/8/2/1  and  S_RD_ADDR_READY  in  1  form the shared-slave address channel.
REQ-010 S_RD_BACK_ID/DATA/RESP/LAST/VALID  in  2/DATA_WIDTH/2/1/1  and  S_RD_DATA_READY  out  1  form the shared-slave data channel.
REQ-011 GRANT  out  1  is the index of the current owner; it is valid outside IDLE.
REQ-012 BURST_ERR  out  1  is a sticky flag for a beat-count/LAST mismatch.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADDR, DATA; exactly one burst is outstanding at a time.
REQ-014 IDLE: if any M*_RD_ADDR_VALID=1, the block SHALL register GRANT and move to ADDR next cycle.
- Both valid: GRANT = round-robin pointer RR.
- One valid: GRANT = that requester.
REQ-015 In IDLE, all ADDR_READY, S_RD_ADDR_VALID, S_RD_DATA_READY and M*_RD_DATA_VALID SHALL be 0.
REQ-016 ADDR: the slave address payload and VALID SHALL combinationally mirror the granted requester.
- M[GRANT]_RD_ADDR_READY = S_RD_ADDR_READY.
- The other requester's READY = 0.
REQ-017 On the slave address handshake, the FSM SHALL enter DATA, latch LEN into exp_len, and clear beat counter cnt (8 bit).
REQ-018 DATA: M[GRANT] data outputs SHALL mirror the slave.
- S_RD_DATA_READY = M[GRANT]_RD_DATA_READY.
- The non-granted requester's DATA_VALID = 0 and its payload = 0.
REQ-019 Each data handshake SHALL increment cnt, which saturates at 255.
REQ-020 A handshake with LAST=1 SHALL return the FSM to IDLE and set RR = ~GRANT.
REQ-021 BURST_ERR SHALL set when a beat with LAST=1 has cnt != exp_len, or a beat with cnt == exp_len has LAST=0.
- The burst still completes only on LAST.
REQ-022 Latency: a request seen in IDLE on cycle n SHALL appear on S_RD_ADDR_VALID on cycle n+1; there is no added latency in ADDR or DATA.
REQ-023 A requester dropping VALID in ADDR is an AXI violation; the block SHALL keep GRANT and wait, with no timeout.
REQ-024 A new request arriving during ADDR or DATA SHALL wait; it is considered only in IDLE.
REQ-025 A LAST handshake and a new request on the same cycle: the request SHALL be arbitrated on the following IDLE cycle using the updated RR.

Reset
REQ-026 While RST=1, on the next edge: state=IDLE, GRANT=0, RR=0, cnt=0, exp_len=0, BURST_ERR=0.
REQ-027 While RST=1, all outputs SHALL be 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no completion of the remaining beats; any in-flight slave data is dropped.

Structure
REQ-029 The state encoding, the ID/LEN/BURST/RESP widths and the INCR burst code (2'b01) SHALL live in shared package axi_pkg.
REQ-030 One sub-module, rr_arbiter2, SHALL hold the RR pointer and produce the grant decision; the datapath muxes stay in the top module.

Verification
REQ-031 M0 only, LEN=3, ADDR=0x100, slave ready always -> 4 beats to M0, LAST on beat 4, GRANT=0, BURST_ERR=0, back to IDLE.
REQ-032 M0 and M1 both valid from reset -> M0 served first, then M1, then M0 again (RR alternates); M1 READY=0 throughout M0's burst.
REQ-033 Slave ADDR_READY held low 5 cycles -> M[GRANT]_RD_ADDR_READY low 5 cycles, payload stable, then a single handshake.
REQ-034 LEN=1 with the slave asserting LAST on beat 1 -> BURST_ERR=1 and stays 1 until RST; the FSM returns to IDLE.
REQ-035 RST=1 pulsed during beat 2 of a LEN=7 burst -> next cycle IDLE, all outputs 0, GRANT=0; a fresh M1 request is then served normally.
